// File: rtl/ex_muldiv_ctrl_if.sv
// ex_muldiv_ctrl_if: EX-stage <-> multiply/divide controller bundle.
// Ports: master = EX side (valid/op/read/flush/A/B out; stall/busy/HI/LO in); slave = MDU side.
interface ex_muldiv_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              EX_MDUValid;
   logic [2:0]        EX_MDUOp;
   logic              EX_HILORead;
   logic              EX_Flush;
   logic [DATA_W-1:0] EX_A;
   logic [DATA_W-1:0] EX_B;
   logic              MDU_Stall;
   logic              MDU_Busy;
   logic [DATA_W-1:0] HI;
   logic [DATA_W-1:0] LO;

   modport master (
      output EX_MDUValid, EX_MDUOp, EX_HILORead, EX_Flush, EX_A, EX_B,
      input  MDU_Stall, MDU_Busy, HI, LO
   );

   modport slave (
      input  EX_MDUValid, EX_MDUOp, EX_HILORead, EX_Flush, EX_A, EX_B,
      output MDU_Stall, MDU_Busy, HI, LO
   );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative radix-2 MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Ports: clk, rst_n (sync, active low), ex (slave: EX op/operands in, stall/busy/HI/LO out).
// Option: define MDU_EARLY_OUT_EN to end a multiply once the multiplier runs out of ones.
module ex_muldiv_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input logic             clk,
   input logic             rst_n,
   ex_muldiv_ctrl_if.slave ex
);
   localparam int W2 = 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [W2-1:0]     acc;
   logic [W2-1:0]     mcand;
   logic [DATA_W-1:0] opb;
   logic [DATA_W-1:0] a_raw;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;
   logic              is_div;
   logic              sign_q;
   logic              sign_r;

   logic op_sgn;
   logic op_mul;
   logic op_div;
   logic op_mthi;
   logic op_mtlo;

   always_comb begin
      op_sgn  = 1'b0;
      op_mul  = 1'b0;
      op_div  = 1'b0;
      op_mthi = 1'b0;
      op_mtlo = 1'b0;
      case (ex.EX_MDUOp)
         3'b001: begin
            op_mul = 1'b1;
            op_sgn = 1'b1;
         end
         3'b010: op_mul = 1'b1;
         3'b011: begin
            op_div = 1'b1;
            op_sgn = 1'b1;
         end
         3'b100: op_div = 1'b1;
         3'b101: op_mthi = 1'b1;
         3'b110: op_mtlo = 1'b1;
         default: ;
      endcase
   end

   logic live;
   logic idle;
   logic issue;
   logic mt_ok;

   assign idle  = (state == IDLE);
   assign live  = ex.EX_MDUValid & ~ex.EX_Flush;
   assign issue = live & idle & (op_mul | op_div);
   assign mt_ok = live & idle;

   logic              a_neg;
   logic              b_neg;
   logic [DATA_W-1:0] a_abs;
   logic [DATA_W-1:0] b_abs;

   assign a_neg = op_sgn & ex.EX_A[DATA_W-1];
   assign b_neg = op_sgn & ex.EX_B[DATA_W-1];
   assign a_abs = a_neg ? -ex.EX_A : ex.EX_A;
   assign b_abs = b_neg ? -ex.EX_B : ex.EX_B;

   // Shifted partial remainder minus divisor. The true result lies in
   // [-d, d-1], so DATA_W+1 bits hold it and the top bit is the sign.
   logic [DATA_W:0] trial;
   assign trial = acc[W2-1:DATA_W-1] - {1'b0, opb};

   logic cnt_end;
   logic last_step;
   assign cnt_end = (cnt == CNT_W'(DATA_W - 1));

`ifdef MDU_EARLY_OUT_EN
   // Stop once the multiplier left after this step is zero.
   assign last_step = cnt_end | (~is_div & ((opb >> 1) == '0));
`else
   assign last_step = cnt_end;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (issue) state_nxt = BUSY;
         BUSY:    if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   logic [W2-1:0]     mul_res;
   logic [DATA_W-1:0] quo;
   logic [DATA_W-1:0] rem;

   assign mul_res = sign_q ? -acc : acc;
   assign quo     = sign_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
   assign rem     = sign_r ? -acc[W2-1:DATA_W] : acc[W2-1:DATA_W];

   // acc: product for MUL; {remainder, dividend/quotient} for DIV.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         opb    <= '0;
         a_raw  <= '0;
         is_div <= 1'b0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (issue) begin
                  cnt    <= '0;
                  is_div <= op_div;
                  a_raw  <= ex.EX_A;
                  sign_q <= a_neg ^ b_neg;
                  sign_r <= a_neg;
                  opb    <= b_abs;
                  mcand  <= {{DATA_W{1'b0}}, a_abs};
                  acc    <= op_div ? {{DATA_W{1'b0}}, a_abs} : '0;
               end else if (mt_ok & op_mthi) begin
                  hi <= ex.EX_A;
               end else if (mt_ok & op_mtlo) begin
                  lo <= ex.EX_A;
               end
            end
            BUSY: begin
               cnt <= cnt + CNT_W'(1);
               if (is_div) begin
                  if (!trial[DATA_W])
                     acc <= {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
                  else
                     acc <= {acc[W2-2:0], 1'b0};
               end else begin
                  if (opb[0]) acc <= acc + mcand;
                  mcand <= {mcand[W2-2:0], 1'b0};
                  opb   <= opb >> 1;
               end
            end
            DONE: begin
               if (is_div) begin
                  if (opb == '0) begin
                     lo <= '1;
                     hi <= a_raw;
                  end else begin
                     lo <= quo;
                     hi <= rem;
                  end
               end else begin
                  hi <= mul_res[W2-1:DATA_W];
                  lo <= mul_res[DATA_W-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign ex.MDU_Busy  = ~idle;
   assign ex.MDU_Stall = (ex.EX_MDUValid | ex.EX_HILORead) & ~idle & ~ex.EX_Flush;
   assign ex.HI        = hi;
   assign ex.LO        = lo;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: scoreboard bench for ex_muldiv_ctrl.
// Expected HI/LO/latency pushed at issue, popped when Busy falls.
module tb_ex_muldiv_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ex_muldiv_ctrl_if #(.DATA_W(32)) bus ();

   ex_muldiv_ctrl #(
      .DATA_W(32),
      .CNT_W (6)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .ex   (bus)
   );

   typedef struct {
      string       tag;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   nvec = 0;
   int   nmis = 0;
   int   busy_n = 0;
   int   n;
   logic [63:0] r;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sbv;
      logic signed [63:0] q;
      logic signed [63:0] rr;
      sa  = {{32{a[31]}}, a};
      sbv = {{32{b[31]}}, b};
      case (op)
         3'b001: return sa * sbv;
         3'b010: return {32'h0, a} * {32'h0, b};
         3'b011: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            q  = sa / sbv;
            rr = sa % sbv;
            return {rr[31:0], q[31:0]};
         end
         3'b100: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'h0;
      endcase
   endfunction

   // Busy cycles: BUSY steps plus the DONE cycle.
   function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
      logic [31:0] m;
      int k;
      m = b;
      k = 1;
`ifdef MDU_EARLY_OUT_EN
      if (op == 3'b001 || op == 3'b010) begin
         if (op == 3'b001 && b[31]) m = -b;
         for (int i = 1; i < 32; i++) if ((m >> i) != 0) k = i + 1;
         return k + 1;
      end
`endif
      return 33 + 0 * (k + int'(m[0]) + int'(op));
   endfunction

   task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic push);
      exp_t e;
      logic [63:0] rv;
      @(negedge clk);
      bus.EX_MDUValid = 1'b1;
      bus.EX_MDUOp    = op;
      bus.EX_A        = a;
      bus.EX_B        = b;
      if (push) begin
         rv    = model(op, a, b);
         e.tag = tag;
         e.hi  = rv[63:32];
         e.lo  = rv[31:0];
         e.lat = exp_busy(op, b);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.EX_MDUValid = 1'b0;
      bus.EX_MDUOp    = 3'b000;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 80 && bus.MDU_Busy; i++) begin
         @(posedge clk);
         #1;
      end
      #1;
      chk({tag, "_idle"}, {63'h0, bus.MDU_Busy}, 64'h0);
   endtask

   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (!rst_n) begin
         sb.delete();
         busy_n = 0;
      end else if (bus.MDU_Busy) begin
         busy_n++;
      end else if (busy_n != 0) begin
         chk("sb_depth", {63'h0, sb.size() != 0}, 64'h1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_hi"}, {32'h0, bus.HI}, {32'h0, e.hi});
            chk({e.tag, "_lo"}, {32'h0, bus.LO}, {32'h0, e.lo});
            chk({e.tag, "_lat"}, 64'(busy_n), 64'(e.lat));
         end
         busy_n = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      bus.EX_MDUValid = 1'b0;
      bus.EX_MDUOp    = 3'b000;
      bus.EX_HILORead = 1'b0;
      bus.EX_Flush    = 1'b0;
      bus.EX_A        = 32'h0;
      bus.EX_B        = 32'h0;
      rst_n           = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_hi", {32'h0, bus.HI}, 64'h0);
      chk("rst_lo", {32'h0, bus.LO}, 64'h0);
      chk("rst_busy", {63'h0, bus.MDU_Busy}, 64'h0);
      chk("rst_stall", {63'h0, bus.MDU_Stall}, 64'h0);

      issue("multu_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      wait_idle("multu_max");
      chk("multu_max_hi_k", {32'h0, bus.HI}, 64'hFFFF_FFFE);
      chk("multu_max_lo_k", {32'h0, bus.LO}, 64'h0000_0001);
      issue("mult_neg", 3'b001, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1);
      wait_idle("mult_neg");
      chk("mult_neg_lo_k", {32'h0, bus.LO}, 64'hFFFF_FFF1);
      issue("div_neg", 3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
      wait_idle("div_neg");
      chk("div_neg_lo_k", {32'h0, bus.LO}, 64'hFFFF_FFFD);
      chk("div_neg_hi_k", {32'h0, bus.HI}, 64'hFFFF_FFFF);
      issue("divu_zero", 3'b100, 32'h0000_000A, 32'h0, 1'b1);
      wait_idle("divu_zero");
      issue("div_zero", 3'b011, 32'hFFFF_FFF0, 32'h0, 1'b1);
      wait_idle("div_zero");
      issue("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_idle("div_ovf");
      chk("div_ovf_lo_k", {32'h0, bus.LO}, 64'h8000_0000);
      issue("div_rem", 3'b011, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1);
      wait_idle("div_rem");
      issue("multu_small", 3'b010, 32'h7, 32'h3, 1'b1);
      wait_idle("multu_small");
      chk("multu_small_lo_k", {32'h0, bus.LO}, 64'd21);

      for (int i = 0; i < 8; i++) begin
         logic [2:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         op = 3'($urandom_range(1, 4));
         a  = $urandom;
         b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
         issue("rnd", op, a, b, 1'b1);
         wait_idle("rnd");
      end

      // HI/LO read during a multiply
      issue("rd_mult", 3'b001, 32'h0000_1234, 32'hFFFF_0003, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.EX_HILORead = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!bus.MDU_Stall) break;
         n++;
         @(negedge clk);
      end
      chk("rd_stall_len", 64'(n), 64'd29);
      r = model(3'b001, 32'h0000_1234, 32'hFFFF_0003);
      chk("rd_sees_new_lo", {32'h0, bus.LO}, {32'h0, r[31:0]});
      bus.EX_HILORead = 1'b0;
      wait_idle("rd_mult");
      @(negedge clk);
      bus.EX_HILORead = 1'b1;
      #1;
      chk("rd_idle_stall", {63'h0, bus.MDU_Stall}, 64'h0);
      bus.EX_HILORead = 1'b0;

      // flush masks stall for one cycle only
      issue("fl_divu", 3'b100, 32'hDEAD_BEEF, 32'h0000_0013, 1'b1);
      @(negedge clk);
      bus.EX_HILORead = 1'b1;
      bus.EX_Flush    = 1'b1;
      #1;
      chk("flush_no_stall", {63'h0, bus.MDU_Stall}, 64'h0);
      bus.EX_Flush = 1'b0;
      #1;
      chk("unflush_stall", {63'h0, bus.MDU_Stall}, 64'h1);
      bus.EX_HILORead = 1'b0;
      wait_idle("fl_divu");

      // MTLO presented during BUSY
      issue("mt_mul", 3'b010, 32'h89AB_CDEF, 32'h0001_2345, 1'b1);
      r = model(3'b010, 32'h89AB_CDEF, 32'h0001_2345);
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.EX_MDUValid = 1'b1;
      bus.EX_MDUOp    = 3'b110;
      bus.EX_A        = 32'hCAFE_0001;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!bus.MDU_Stall) break;
         n++;
         @(negedge clk);
      end
      chk("mtlo_stall_len", 64'(n), 64'd30);
      @(posedge clk);
      #2;
      bus.EX_MDUValid = 1'b0;
      bus.EX_MDUOp    = 3'b000;
      chk("mtlo_lo", {32'h0, bus.LO}, 64'hCAFE_0001);
      chk("mtlo_hi", {32'h0, bus.HI}, {32'h0, r[63:32]});
      chk("mtlo_busy", {63'h0, bus.MDU_Busy}, 64'h0);

      // MTHI flushed, then MTHI live
      @(negedge clk);
      bus.EX_MDUValid = 1'b1;
      bus.EX_MDUOp    = 3'b101;
      bus.EX_A        = 32'h5555_AAAA;
      bus.EX_Flush    = 1'b1;
      @(posedge clk);
      #1;
      chk("mthi_flushed", {32'h0, bus.HI}, {32'h0, r[63:32]});
      @(negedge clk);
      bus.EX_Flush = 1'b0;
      #1;
      chk("mthi_no_stall", {63'h0, bus.MDU_Stall}, 64'h0);
      @(posedge clk);
      #1;
      bus.EX_MDUValid = 1'b0;
      chk("mthi_hi", {32'h0, bus.HI}, 64'h5555_AAAA);

      // reset in the middle of a multiply
      issue("rst_mult", 3'b001, 32'h0000_0007, 32'h0000_0009, 1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_hi", {32'h0, bus.HI}, 64'h0);
      chk("midrst_lo", {32'h0, bus.LO}, 64'h0);
      chk("midrst_busy", {63'h0, bus.MDU_Busy}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      issue("post_rst_divu", 3'b100, 32'd1000, 32'd7, 1'b1);
      wait_idle("post_rst_divu");

      // issue together with flush never starts
      @(negedge clk);
      bus.EX_MDUValid = 1'b1;
      bus.EX_MDUOp    = 3'b001;
      bus.EX_A        = 32'h1234_5678;
      bus.EX_B        = 32'h0000_0002;
      bus.EX_Flush    = 1'b1;
      @(posedge clk);
      #1;
      chk("flush_issue_busy", {63'h0, bus.MDU_Busy}, 64'h0);
      bus.EX_MDUValid = 1'b0;
      bus.EX_Flush    = 1'b0;
      @(posedge clk);
      #1;
      chk("flush_issue_busy2", {63'h0, bus.MDU_Busy}, 64'h0);

      repeat (2) @(posedge clk);
      #2;
      chk("sb_drained", 64'(sb.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
